// File: rtl/lieat_pipe_flowctl.sv
// Central valid/load-enable controller for a STAGES-deep pipeline.
// Handles stalls with same-cycle bubble collapse, partial flushes and a post-reset boot window.
module lieat_pipe_flowctl #(
    parameter int STAGES   = 7,
    parameter int BOOT_CYC = 2,
    parameter int CNTW     = 16,
    parameter int FW       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [STAGES-1:0] stall_req,
    input  logic              flush_valid,
    input  logic [FW-1:0]     flush_stage,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [STAGES-1:0] stage_loaden,
    output logic [STAGES-1:0] stage_valid,
    output logic              boot_done,
    input  logic              perf_clr,
    output logic [CNTW-1:0]   perf_stall_cnt
);

    localparam int BW = (BOOT_CYC > 0) ? $clog2(BOOT_CYC + 1) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYC);

    logic [BW-1:0]     bootCnt_q, bootCnt_d;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [CNTW-1:0]   perfCnt_q, perfCnt_d;
    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] killMask;
    logic              bootDone;

    // Gating with reset makes every handshake output idle combinationally while reset is asserted.
    assign bootDone = reset & (bootCnt_q == BOOT_LAST);

    always_comb begin
        hold = '0;
        hold[STAGES-1] = valid_q[STAGES-1] & (stall_req[STAGES-1] | ~out_ready);
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold[i] = valid_q[i] & (stall_req[i] | hold[i+1]);
        end
    end

    always_comb begin
        killMask = '0;
        for (int i = 0; i < STAGES; i++) begin
            killMask[i] = flush_valid & (int'(flush_stage) >= i);
        end
    end

    assign stage_loaden   = bootDone ? ~hold : '1;
    assign in_ready       = bootDone & ~hold[0] & ~flush_valid;
    assign out_valid      = bootDone & valid_q[STAGES-1] & ~stall_req[STAGES-1];
    assign stage_valid    = valid_q;
    assign boot_done      = bootDone;
    assign perf_stall_cnt = perfCnt_q;

    // A stage whose predecessor is being flushed receives a bubble rather than the killed entry.
    always_comb begin
        valid_d = valid_q;
        if (!bootDone) begin
            valid_d = '0;
        end else begin
            if (!hold[0]) begin
                valid_d[0] = in_valid & in_ready;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (!hold[i]) begin
                    valid_d[i] = valid_q[i-1] & ~hold[i-1] & ~killMask[i-1];
                end
            end
            valid_d = valid_d & ~killMask;
        end
    end

    always_comb begin
        bootCnt_d = bootCnt_q;
        if (bootCnt_q != BOOT_LAST) begin
            bootCnt_d = bootCnt_q + 1'b1;
        end
    end

    always_comb begin
        perfCnt_d = perfCnt_q;
        if (perf_clr) begin
            perfCnt_d = '0;
        end else if (bootDone && in_valid && !in_ready && !(&perfCnt_q)) begin
            perfCnt_d = perfCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bootCnt_q <= '0;
            valid_q   <= '0;
            perfCnt_q <= '0;
        end else begin
            bootCnt_q <= bootCnt_d;
            valid_q   <= valid_d;
            perfCnt_q <= perfCnt_d;
        end
    end

endmodule

// File: tb/tb_lieat_pipe_flowctl.sv
// Scoreboard bench: a shadow datapath driven by stage_loaden carries instruction ids,
// and a slot-level occupancy model predicts handshakes, valid bits and retire order.
module tb_lieat_pipe_flowctl;

    localparam int STAGES   = 7;
    localparam int BOOT_CYC = 2;
    localparam int CNTW     = 16;
    localparam int FW       = 3;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [STAGES-1:0] stall_req;
    logic              flush_valid;
    logic [FW-1:0]     flush_stage;
    logic              out_valid;
    logic              out_ready;
    logic [STAGES-1:0] stage_loaden;
    logic [STAGES-1:0] stage_valid;
    logic              boot_done;
    logic              perf_clr;
    logic [CNTW-1:0]   perf_stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    lieat_pipe_flowctl #(
        .STAGES(STAGES), .BOOT_CYC(BOOT_CYC), .CNTW(CNTW), .FW(FW)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .stall_req(stall_req),
        .flush_valid(flush_valid), .flush_stage(flush_stage),
        .out_valid(out_valid), .out_ready(out_ready),
        .stage_loaden(stage_loaden), .stage_valid(stage_valid),
        .boot_done(boot_done),
        .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state: one id per slot (-1 = empty), cycles since release, counter.
    int mSlot[STAGES];
    int mSince = 0;
    int mPerf  = 0;
    int nextId = 1;
    int expQ[$];

    bit eStuck[STAGES];
    bit eLeave[STAGES];
    bit eBoot;
    bit eInReady;
    bit eOutValid;
    logic [STAGES-1:0] eLoaden;
    logic [STAGES-1:0] eOcc;

    // Shadow data registers that only move when the controller enables them.
    int shData[STAGES];

    initial begin
        for (int i = 0; i < STAGES; i++) begin
            mSlot[i]  = -1;
            shData[i] = 0;
        end
    end

    always @(posedge clock) begin
        if (stage_loaden[0]) shData[0] <= nextId;
        for (int i = 1; i < STAGES; i++) begin
            if (stage_loaden[i]) shData[i] <= shData[i-1];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // An entry leaves when not stalled and its destination is (or becomes) free this cycle.
    task automatic evalComb();
        bit destFree;
        bit occ;
        destFree = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            occ       = (mSlot[i] >= 0);
            eLeave[i] = occ && !stall_req[i] && destFree;
            eStuck[i] = occ && !eLeave[i];
            eOcc[i]   = occ;
            destFree  = !occ || eLeave[i];
        end
        eBoot = reset && (mSince >= BOOT_CYC);
        if (eBoot) begin
            for (int i = 0; i < STAGES; i++) eLoaden[i] = !eStuck[i];
            eInReady  = destFree && !flush_valid;
            eOutValid = eOcc[STAGES-1] && !stall_req[STAGES-1];
        end else begin
            eLoaden   = '1;
            eInReady  = 1'b0;
            eOutValid = 1'b0;
        end
    endtask

    task automatic killId(input int id);
        int found;
        found = -1;
        for (int k = 0; k < expQ.size(); k++) begin
            if (found < 0 && expQ[k] == id) found = k;
        end
        if (found >= 0) expQ.delete(found);
    endtask

    always @(posedge clock or negedge reset) begin
        int ns[STAGES];
        int f;
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) mSlot[i] = -1;
            mSince = 0;
            mPerf  = 0;
            expQ.delete();
        end else begin
            evalComb();
            if (eBoot) begin
                for (int i = 0; i < STAGES; i++) begin
                    if (eStuck[i]) ns[i] = mSlot[i];
                    else if (i == 0) ns[i] = (in_valid && eInReady) ? nextId : -1;
                    else ns[i] = eLeave[i-1] ? mSlot[i-1] : -1;
                end
                if (in_valid && eInReady) begin
                    expQ.push_back(nextId);
                    nextId <= nextId + 1;
                end
                if (flush_valid) begin
                    f = int'(flush_stage);
                    for (int i = 0; i < STAGES; i++) begin
                        if (i <= f) begin
                            if (mSlot[i] >= 0) killId(mSlot[i]);
                            ns[i] = -1;
                        end
                    end
                    if (f + 1 < STAGES && !eStuck[f+1]) ns[f+1] = -1;
                end
                for (int i = 0; i < STAGES; i++) mSlot[i] = ns[i];
            end
            if (perf_clr) mPerf = 0;
            else if (eBoot && in_valid && !eInReady && mPerf < 65535) mPerf++;
            if (mSince < BOOT_CYC) mSince++;
        end
    end

    // Monitor: compare the DUT against the model mid-cycle and pop the scoreboard on each retire.
    always @(negedge clock) begin
        int expId;
        evalComb();
        checkOutput("boot_done", boot_done, eBoot);
        checkOutput("stage_valid", stage_valid, eBoot ? eOcc : '0);
        checkOutput("stage_loaden", stage_loaden, eLoaden);
        checkOutput("in_ready", in_ready, eInReady);
        checkOutput("out_valid", out_valid, eOutValid);
        checkOutput("perf_stall_cnt", perf_stall_cnt, mPerf);
        if (eOutValid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("retire_queue_empty", 1, 0);
            end else begin
                expId = expQ.pop_front();
                checkOutput("retire_id", shData[STAGES-1], expId);
            end
        end
    end

    task automatic applyStimulus(input bit inV, input logic [STAGES-1:0] stall, input bit flV,
                                 input logic [FW-1:0] flS, input bit outR, input bit clr,
                                 input int cycles);
        in_valid    = inV;
        stall_req   = stall;
        flush_valid = flV;
        flush_stage = flS;
        out_ready   = outR;
        perf_clr    = clr;
        repeat (cycles) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        bit rv;
        bit rf;
        bit ro;
        logic [STAGES-1:0] rs;
        logic [FW-1:0] rfs;

        reset = 1'b0;
        applyStimulus(1, '0, 0, '0, 1, 0, 3);
        reset = 1'b1;
        $display("[TB] boot window and first accept");
        applyStimulus(1, '0, 0, '0, 1, 0, 12);

        $display("[TB] stream with drain");
        applyStimulus(1, '0, 0, '0, 1, 0, 10);
        applyStimulus(0, '0, 0, '0, 1, 0, 10);

        $display("[TB] stall in middle of full pipe");
        applyStimulus(1, '0, 0, '0, 0, 0, 10);
        applyStimulus(1, 7'h08, 0, '0, 1, 0, 3);
        applyStimulus(1, '0, 0, '0, 1, 0, 5);
        applyStimulus(0, '0, 0, '0, 1, 0, 10);

        $display("[TB] bubble collapse");
        applyStimulus(1, '0, 0, '0, 0, 0, 1);
        applyStimulus(0, '0, 0, '0, 0, 0, 1);
        applyStimulus(1, '0, 0, '0, 0, 0, 1);
        checkOutput("collapse_pattern", stage_valid, 7'b0000101);
        applyStimulus(0, '0, 0, '0, 0, 0, 8);
        checkOutput("collapse_packed", stage_valid, 7'b1100000);
        applyStimulus(0, '0, 0, '0, 1, 0, 4);

        $display("[TB] flush stage 3 on full pipe");
        applyStimulus(1, '0, 0, '0, 0, 0, 10);
        applyStimulus(1, '0, 1, 3'd3, 1, 0, 1);
        checkOutput("flush_valid_bits", stage_valid, 7'b1100000);
        applyStimulus(0, '0, 0, '0, 1, 0, 6);

        $display("[TB] asynchronous reset pulse");
        applyStimulus(1, '0, 0, '0, 0, 0, 10);
        reset = 1'b0;
        #1;
        checkOutput("async_stage_valid", stage_valid, '0);
        checkOutput("async_loaden", stage_loaden, 7'h7F);
        checkOutput("async_in_ready", in_ready, 0);
        checkOutput("async_perf", perf_stall_cnt, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        $display("[TB] counter saturation and clear");
        applyStimulus(1, '1, 0, '0, 0, 0, 65560);
        checkOutput("perf_saturated", perf_stall_cnt, 16'hFFFF);
        applyStimulus(1, '1, 0, '0, 0, 1, 1);
        checkOutput("perf_cleared", perf_stall_cnt, 0);
        applyStimulus(0, '0, 0, '0, 1, 0, 10);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            rv = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < STAGES; i++) rs[i] = ($urandom_range(0, 9) == 0);
            rf  = ($urandom_range(0, 19) == 0);
            rfs = FW'($urandom_range(0, 7));
            ro  = ($urandom_range(0, 3) != 0);
            if (rf && int'(rfs) >= STAGES - 1) ro = 1'b0;
            applyStimulus(rv, rs, rf, rfs, ro, ($urandom_range(0, 99) == 0), 1);
        end
        applyStimulus(0, '0, 0, '0, 1, 0, 12);
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
